// File: rtl/hdlc_axil_pkg.sv
// Shared definitions for the HDLC AXI4-Lite register slave: response code,
// register count and indices, the register index type and the FSM state types.
package hdlc_axil_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam int         NUM_REGS  = 4;

    typedef logic [1:0] reg_idx_t;

    localparam reg_idx_t REG_CTRL = 2'd0;
    localparam reg_idx_t REG_TXD  = 2'd1;
    localparam reg_idx_t REG_CFG  = 2'd2;
    localparam reg_idx_t REG_AUX  = 2'd3;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/hdlc_axil_wstrb_merge.sv
// Byte-lane merge of a register's current value with incoming write data.
// Ports:
//   old_data  current register contents
//   new_data  write data from the bus
//   wstrb     byte enables; a 0 bit keeps the old byte
//   merged    next register value
module hdlc_axil_wstrb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/hdlc_axil_slave_regs.sv
// AXI4-Lite slave with four 32-bit read/write registers for the HDLC core.
// Ports:
//   ACLK, ARESETN        clock and synchronous active-low reset
//   S_AXI_AW*/W*/B*      single-beat write address, data and response channels
//   S_AXI_AR*/R*         single-beat read address and data channels
//   reg_out              flattened register contents, reg0 in [31:0]
//   reg_wr_strobe        one-cycle pulse per register, aligned with BVALID rising
// Both responses are always OKAY; address bits [1:0] and PROT are ignored.
module hdlc_axil_slave_regs
    import hdlc_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]               reg_wr_strobe
);

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0] merged;

    reg_idx_t w_idx;
    reg_idx_t r_idx;
    logic     wr_fire;

    // Bits the register map does not decode.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_idx = reg_idx_t'(S_AXI_AWADDR[3:2]);
    assign r_idx = reg_idx_t'(S_AXI_ARADDR[3:2]);

    // Ready/valid are decoded from the state registers, so they are glitch-free
    // and the one-cycle ready pulse falls out of the one-cycle ACK state.
    assign S_AXI_AWREADY = (w_state == W_ACK);
    assign S_AXI_WREADY  = (w_state == W_ACK);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = (r_state == R_ACK);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RRESP   = RESP_OKAY;

    // The ACK state is the handshake edge: the master still holds AW/W valid.
    assign wr_fire = (w_state == W_ACK);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
                    w_state_next = W_ACK;
                end
            end
            W_ACK:  w_state_next = W_RESP;
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (S_AXI_ARVALID && !S_AXI_RVALID) begin
                    r_state_next = R_ACK;
                end
            end
            R_ACK:  r_state_next = R_DATA;
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    hdlc_axil_wstrb_merge #(
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_wstrb_merge (
        .old_data (regs[w_idx]),
        .new_data (S_AXI_WDATA),
        .wstrb    (S_AXI_WSTRB),
        .merged   (merged)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_wr_strobe <= '0;
        end else begin
            if (wr_fire) begin
                regs[w_idx] <= merged;
            end
            reg_wr_strobe <= wr_fire ? (NUM_REGS'(1) << w_idx) : '0;
        end
    end

    // Captured with non-blocking semantics, so a write landing on the same
    // edge is not yet visible and the read returns the old value.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            S_AXI_RDATA <= '0;
        end else if (r_state == R_ACK) begin
            S_AXI_RDATA <= regs[r_idx];
        end
    end

    assign reg_out = {regs[REG_AUX], regs[REG_CFG], regs[REG_TXD], regs[REG_CTRL]};

endmodule

// File: tb/tb_hdlc_axil_slave_regs.sv
module tb_hdlc_axil_slave_regs;

    logic         clk = 1'b0;
    logic         aresetn;
    logic [3:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [3:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] reg_out;
    logic [3:0]   reg_wr_strobe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hdlc_axil_slave_regs dut (
        .ACLK          (clk),
        .ARESETN       (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_wr_strobe (reg_wr_strobe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full write with BREADY high; checks ready pulse, response and strobe.
    task automatic axi_write(input string tag, input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [3:0] exp_strobe);
        int n;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        n = 0;
        while (!awready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " awready&wready"}, {awready, wready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, " bvalid"}, bvalid, 1'b1);
        check({tag, " bresp"}, bresp, 2'b00);
        check({tag, " strobe"}, reg_wr_strobe, exp_strobe);
        tick();
        check({tag, " bvalid done"}, {bvalid, reg_wr_strobe}, 5'b0);
    endtask

    // Full read with RREADY high; checks data and response.
    task automatic axi_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        check({tag, " arready"}, arready, 1'b1);
        tick();
        arvalid = 1'b0;
        check({tag, " rvalid"}, rvalid, 1'b1);
        check({tag, " rdata"}, rdata, exp);
        check({tag, " rresp"}, rresp, 2'b00);
        tick();
        check({tag, " rvalid done"}, rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        tick(); tick(); tick();

        // Reset state
        check("rst readies", {awready, wready, arready}, 3'b000);
        check("rst valids", {bvalid, rvalid}, 2'b00);
        check("rst rdata", rdata, 32'h0);
        check("rst reg_out", reg_out, 128'h0);
        check("rst strobe", reg_wr_strobe, 4'b0000);
        aresetn = 1'b1;
        tick();

        // Sequential writes and read-back
        axi_write("w0", 4'h0, 32'h1, 4'hF, 4'b0001);
        axi_write("w1", 4'h4, 32'h2, 4'hF, 4'b0010);
        axi_write("w2", 4'h8, 32'h3, 4'hF, 4'b0100);
        axi_write("w3", 4'hC, 32'h4, 4'hF, 4'b1000);
        check("reg_out seq", reg_out, {32'h4, 32'h3, 32'h2, 32'h1});
        axi_read("r0", 4'h0, 32'h1);
        axi_read("r1", 4'h4, 32'h2);
        axi_read("r2", 4'h8, 32'h3);
        axi_read("r3", 4'hF, 32'h4);

        // Byte strobes
        axi_write("wff", 4'h4, 32'hFFFF_FFFF, 4'hF, 4'b0010);
        axi_write("wpart", 4'h5, 32'h1234_5678, 4'b0101, 4'b0010);
        axi_read("rpart", 4'h4, 32'hFF34_FF78);
        axi_write("wzero", 4'hC, 32'hDEAD_BEEF, 4'b0000, 4'b1000);
        axi_read("rzero", 4'hC, 32'h4);

        // AW three cycles ahead of W
        awaddr = 4'h0; wdata = 32'hCAFE_0000; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("aw-only ready", {awready, wready}, 2'b00);
        end
        wvalid = 1'b1;
        tick();
        check("aw+w ready", {awready, wready, bvalid}, 3'b110);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("aw+w bvalid", {awready, wready, bvalid}, 3'b001);
        tick();
        check("aw+w reg0", reg_out[31:0], 32'hCAFE_0000);

        // BREADY back-pressure with a second write pending
        bready = 1'b0;
        awaddr = 4'h8; wdata = 32'h11; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        tick(); tick();
        awaddr = 4'h0; wdata = 32'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp hold", {bvalid, awready, wready}, 3'b100);
        end
        bready = 1'b1;
        tick();
        check("bp release", {bvalid, awready}, 2'b00);
        tick();
        check("bp second ready", awready, 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp second bvalid", bvalid, 1'b1);
        tick();
        check("bp regs", {reg_out[95:64], reg_out[31:0]}, {32'h11, 32'h22});

        // RREADY back-pressure: data stays stable while the register changes
        rready = 1'b0; araddr = 4'h8; arvalid = 1'b1;
        tick(); tick();
        arvalid = 1'b0;
        check("rbp rdata", {rvalid, rdata}, {1'b1, 32'h11});
        axi_write("rbp w", 4'h8, 32'h33, 4'hF, 4'b0100);
        araddr = 4'h0; arvalid = 1'b1;
        tick();
        check("rbp hold", {rvalid, arready, rdata}, {1'b1, 1'b0, 32'h11});
        arvalid = 1'b0; rready = 1'b1;
        tick();
        check("rbp release", rvalid, 1'b0);

        // Concurrent read and write of the same register on the same edge
        axi_write("cc pre", 4'h8, 32'hA, 4'hF, 4'b0100);
        awaddr = 4'h8; wdata = 32'hB; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        tick();
        check("cc readies", {awready, arready}, 2'b11);
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("cc old data", {bvalid, rvalid, rdata}, {1'b1, 1'b1, 32'hA});
        tick();
        axi_read("cc new", 4'h8, 32'hB);

        // Reset in the middle of a read
        rready = 1'b0; araddr = 4'h4; arvalid = 1'b1;
        tick(); tick();
        arvalid = 1'b0;
        check("mid rvalid", {rvalid, rdata}, {1'b1, 32'hFF34_FF78});
        aresetn = 1'b0;
        tick();
        check("mid rst valid", {rvalid, bvalid, arready, awready}, 4'b0000);
        check("mid rst rdata", rdata, 32'h0);
        check("mid rst reg_out", reg_out, 128'h0);
        aresetn = 1'b1; rready = 1'b1;
        tick();
        axi_read("post0", 4'h0, 32'h0);
        axi_read("post1", 4'h4, 32'h0);
        axi_read("post2", 4'h8, 32'h0);
        axi_read("post3", 4'hC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_axil_slave_regs.md
Name: hdlc_axil_slave_regs

Overview:
AXI4-Lite slave register file that sits on the HDLC controller's S00_AXI port, behind the master VIP.
Provides four 32-bit read/write registers at byte offsets 0x0, 0x4, 0x8 and 0xC.
Exposes the register contents and one-cycle write strobes to the HDLC core.
Responds to single-beat AXI4-Lite writes and reads with OKAY responses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, address width; ADDR[3:2] selects the register.

Ports:
ACLK  in  1  single clock; all logic on the rising edge.
ARESETN  in  1  synchronous active-low reset.
S_AXI_AWADDR  in  4  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  write response; always 2'b00.
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  4  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response; always 2'b00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
reg_out  out  4x32  current register contents, flattened 128 bits; reg0 in [31:0].
reg_wr_strobe  out  4  one-cycle pulse per register after that register is written.

Behaviour:
- Reset: sampled on the ACLK edge while ARESETN=0. All registers, *READY, *VALID, RDATA and reg_wr_strobe go to 0. Any in-flight transaction is dropped; no response is issued for it.
- Write FSM, states W_IDLE -> W_ACK -> W_RESP:
  - W_IDLE: when AWVALID & WVALID & !BVALID, go to W_ACK. AWREADY and WREADY assert together for exactly one cycle.
  - W_ACK (handshake edge): latch AWADDR[3:2]. Update the selected register byte-wise per WSTRB; a byte with strobe 0 keeps its old value. Assert BVALID next cycle; go to W_RESP.
  - W_RESP: hold BVALID and BRESP=00 until BREADY is sampled high, then go to W_IDLE.
  - AW without W, or W without AW: no ready is asserted; the slave waits for both.
- Write latency: ready 1 cycle after both valids; BVALID 2 cycles after both valids.
- reg_wr_strobe[idx]: high for the single cycle after the handshake edge, aligned with BVALID rising. WSTRB=0 still pulses the strobe with the register unchanged.
- Read FSM, states R_IDLE -> R_ACK -> R_DATA:
  - R_IDLE: when ARVALID & !RVALID, go to R_ACK. ARREADY asserts for exactly one cycle.
  - R_ACK (handshake edge): capture the register at ARADDR[3:2] into RDATA. Go to R_DATA with RVALID=1.
  - R_DATA: hold RVALID, RDATA and RRESP=00 stable until RREADY is sampled high, then go to R_IDLE.
- Read latency: ARREADY 1 cycle after ARVALID; RVALID 2 cycles after ARVALID.
- Write and read FSMs are independent and may run concurrently.
- Same-edge write handshake and read capture to the same register: the read returns the pre-write value.
- ADDR[1:0] are ignored, so all addresses decode and there is no SLVERR. AWPROT and ARPROT are ignored.
- Back-pressure: BREADY or RREADY held low stalls only its own channel. A new AW/W is not accepted while BVALID=1; a new AR is not accepted while RVALID=1.

Decomposition:
- Package hdlc_axil_pkg holds:
  - RESP_OKAY = 2'b00.
  - NUM_REGS = 4.
  - Register index constants REG_CTRL=0, REG_TXD=1, REG_CFG=2, REG_AUX=3.
  - Typedef reg_idx_t (2 bits).
- One sub-module, hdlc_axil_wstrb_merge: combinational merge of old data, new data and WSTRB into the next register value.

Test Plan:
- Reset then sequential writes 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back -> each BRESP=00; RDATA=0x1, 0x2, 0x3, 0x4; reg_wr_strobe pulses 0001, 0010, 0100, 1000.
- Write 0xFFFFFFFF to 0x4, then 0x12345678 with WSTRB=0101 -> reading 0x4 returns 0xFF34FF78.
- AWVALID asserted 3 cycles before WVALID -> AWREADY/WREADY stay 0 until both are valid; then both are ready for one cycle and BVALID follows 1 cycle later.
- Hold BREADY=0 for 5 cycles after a write, while issuing a second AW/W -> BVALID stays high and the second write is not accepted until BREADY; RREADY=0 likewise holds RDATA stable.
- Register 0x8 holds 0xA; concurrent read of 0x8 and write 0xB to 0x8, both handshaking on the same edge -> RDATA=0xA; a later read returns 0xB.
- Deassert ARESETN mid-read with RVALID=1 -> next cycle RVALID=0, all registers read 0 and reg_out=0.
